// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter that owns the 2-to-1 mux select, with bounded hold and a turnaround gap.
// Optional switch counter enabled by defining MUX_SWITCH_COUNT_EN.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned TURN     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_x,
  input  logic             req_y,
  output logic             sel,
  output logic             gnt_x,
  output logic             gnt_y,
`ifdef MUX_SWITCH_COUNT_EN
  output logic             busy,
  output logic [CNT_W-1:0] switch_cnt
`else
  output logic             busy
`endif
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  localparam int unsigned TW = $clog2(TURN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_GRANT_X = 2'd2;
  localparam logic [1:0] ST_GRANT_Y = 2'd3;

  if (HOLD_MAX < 1 || TURN < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("mux_sel_arbiter: HOLD_MAX, TURN and CNT_W must all be >= 1");
  end

  logic [1:0]    state_r;
  logic          sel_r;
  logic          gnt_x_r;
  logic          gnt_y_r;
  logic          busy_r;
  logic [HW-1:0] hold_cnt_r;
  logic [TW-1:0] turn_cnt_r;
  logic          last_r;

  logic [1:0]    state_s;
  logic [HW-1:0] hold_cnt_s;
  logic [TW-1:0] turn_cnt_s;
  logic          last_s;
  logic          to_settle_s;
  logic          tgt_s;

  logic [1:0]    state_nxt_s;
  logic          sel_nxt_s;
  logic [TW-1:0] turn_nxt_s;

  // Next-state decision; every move into SETTLE is funnelled through to_settle_s/tgt_s.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    turn_cnt_s  = turn_cnt_r;
    last_s      = last_r;
    to_settle_s = 1'b0;
    tgt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_x && req_y) begin
          tgt_s = ~last_r;
        end else begin
          tgt_s = req_y;
        end
        if (req_x || req_y) begin
          if (tgt_s == sel_r) begin
            state_s    = tgt_s ? ST_GRANT_Y : ST_GRANT_X;
            hold_cnt_s = {HW{1'b0}};
            last_s     = tgt_s;
          end else begin
            to_settle_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (turn_cnt_r == TURN_LAST) begin
          if (sel_r ? req_y : req_x) begin
            state_s    = sel_r ? ST_GRANT_Y : ST_GRANT_X;
            hold_cnt_s = {HW{1'b0}};
            last_s     = sel_r;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          turn_cnt_s = turn_cnt_r + 1'b1;
        end
      end
      ST_GRANT_X: begin
        if (!req_x) begin
          if (req_y) begin
            tgt_s       = 1'b1;
            to_settle_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (req_y && hold_cnt_r == HOLD_LAST) begin
          tgt_s       = 1'b1;
          to_settle_s = 1'b1;
        end else if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_s = hold_cnt_r + 1'b1;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      ST_GRANT_Y: begin
        if (!req_y) begin
          if (req_x) begin
            tgt_s       = 1'b0;
            to_settle_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (req_x && hold_cnt_r == HOLD_LAST) begin
          tgt_s       = 1'b0;
          to_settle_s = 1'b1;
        end else if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_s = hold_cnt_r + 1'b1;
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign state_nxt_s = to_settle_s ? ST_SETTLE : state_s;
  assign sel_nxt_s   = to_settle_s ? tgt_s : sel_r;
  assign turn_nxt_s  = to_settle_s ? {TW{1'b0}} : turn_cnt_s;

  // State and registered outputs; grants derive from the next state so they never overlap a sel change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      sel_r      <= 1'b0;
      gnt_x_r    <= 1'b0;
      gnt_y_r    <= 1'b0;
      busy_r     <= 1'b0;
      hold_cnt_r <= {HW{1'b0}};
      turn_cnt_r <= {TW{1'b0}};
      last_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      sel_r      <= sel_nxt_s;
      gnt_x_r    <= (state_nxt_s == ST_GRANT_X);
      gnt_y_r    <= (state_nxt_s == ST_GRANT_Y);
      busy_r     <= (state_nxt_s != ST_IDLE);
      hold_cnt_r <= hold_cnt_s;
      turn_cnt_r <= turn_nxt_s;
      last_r     <= last_s;
    end
  end

  assign sel   = sel_r;
  assign gnt_x = gnt_x_r;
  assign gnt_y = gnt_y_r;
  assign busy  = busy_r;

`ifdef MUX_SWITCH_COUNT_EN
  logic [CNT_W-1:0] switch_cnt_r;

  // Counts entries into SETTLE, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      switch_cnt_r <= {CNT_W{1'b0}};
    end else if (to_settle_s) begin
      switch_cnt_r <= switch_cnt_r + 1'b1;
    end else begin
      switch_cnt_r <= switch_cnt_r;
    end
  end

  assign switch_cnt = switch_cnt_r;
`else
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: a driver feeds a high-level ownership model and queues
// expectations; a monitor pops and compares after every rising edge.
module tb_mux_sel_arbiter;
  localparam int unsigned HOLD_MAX = 8;
  localparam int unsigned TURN     = 1;
  localparam int unsigned CNT_W    = 4;

  logic clk = 1'b0;
  logic resetn;
  logic req_x, req_y;
  logic sel, gnt_x, gnt_y, busy;
`ifdef MUX_SWITCH_COUNT_EN
  logic [CNT_W-1:0] switch_cnt;
`endif

  mux_sel_arbiter #(.HOLD_MAX(HOLD_MAX), .TURN(TURN), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .req_x(req_x), .req_y(req_y),
    .sel(sel), .gnt_x(gnt_x), .gnt_y(gnt_y),
`ifdef MUX_SWITCH_COUNT_EN
    .busy(busy), .switch_cnt(switch_cnt)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic        gx;
    logic        gy;
    logic        busy;
    logic [31:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: who owns the output, how long they have held it, how much gap remains.
  bit          m_sel;
  int          m_owner;   // 0 none, 1 X, 2 Y
  int          m_gap;     // turnaround cycles still to run
  int          m_run;     // cycles the current owner has been granted
  bit          m_last;    // side that was granted most recently (1 = Y)
  int unsigned m_sw;

  function automatic void model_reset();
    m_sel = 1'b0; m_owner = 0; m_gap = 0; m_run = 0; m_last = 1'b1; m_sw = 0;
  endfunction

  function automatic void m_grant(bit s);
    m_owner = s ? 2 : 1; m_run = 1; m_last = s;
  endfunction

  function automatic void m_switch(bit s);
    m_owner = 0; m_sel = s; m_gap = TURN; m_sw++;
  endfunction

  function automatic void model_step(bit rx, bit ry);
    bit r[2];
    bit s;
    r[0] = rx; r[1] = ry;
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        if (r[m_sel]) m_grant(m_sel);
        else m_owner = 0;
      end
    end else if (m_owner == 0) begin
      if (rx || ry) begin
        s = (rx && ry) ? !m_last : ry;
        if (s == m_sel) m_grant(s);
        else m_switch(s);
      end
    end else begin
      s = (m_owner == 2);
      if (!r[s]) begin
        if (r[!s]) m_switch(!s);
        else m_owner = 0;
      end else if (r[!s] && m_run >= HOLD_MAX) begin
        m_switch(!s);
      end else begin
        m_run++;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.sel  = m_sel;
    e.gx   = (m_owner == 1);
    e.gy   = (m_owner == 2);
    e.busy = (m_owner != 0) || (m_gap > 0);
    e.sw   = m_sw % (32'd1 << CNT_W);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per rising edge once the driver has queued one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sel", int'(sel), int'(e.sel));
        check("gnt_x", int'(gnt_x), int'(e.gx));
        check("gnt_y", int'(gnt_y), int'(e.gy));
        check("busy", int'(busy), int'(e.busy));
        check("gnt_exclusive", int'(gnt_x && gnt_y), 0);
        check("gnt_sel_match", int'((gnt_x && sel) || (gnt_y && !sel)), 0);
`ifdef MUX_SWITCH_COUNT_EN
        check("switch_cnt", int'(switch_cnt), int'(e.sw[CNT_W-1:0]));
`endif
      end
    end
  end

  task automatic cycle(input bit rx, input bit ry);
    @(negedge clk);
    req_x = rx;
    req_y = ry;
    model_step(rx, ry);
    exp_q.push_back(model_out());
  endtask

  // Async reset pulse placed between edges; outputs must clear without a clock.
  task automatic async_reset(input bit chk_pre_gy);
    @(posedge clk);
    #2;
    if (chk_pre_gy) check("t5_gnt_y_before_reset", int'(gnt_y), 1);
    resetn = 1'b0;
    #1;
    check("rst_sel", int'(sel), 0);
    check("rst_gnt_x", int'(gnt_x), 0);
    check("rst_gnt_y", int'(gnt_y), 0);
    check("rst_busy", int'(busy), 0);
`ifdef MUX_SWITCH_COUNT_EN
    check("rst_switch_cnt", int'(switch_cnt), 0);
`endif
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    bit rx, ry;
    resetn = 1'b0;
    req_x  = 1'b0;
    req_y  = 1'b0;
    model_reset();
    #12;
    check("init_sel", int'(sel), 0);
    check("init_gnt_x", int'(gnt_x), 0);
    check("init_gnt_y", int'(gnt_y), 0);
    check("init_busy", int'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;

    // X alone: granted on the first edge, sel never moves.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);

    // Y alone from reset: one turnaround cycle, then grant.
    async_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Simultaneous requests from reset, held 40 cycles: X first, then alternating bursts.
    async_reset(1'b0);
    repeat (40) cycle(1'b1, 1'b1);

    // Reset in the middle of a Y grant, then X follows one edge after release.
    async_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    async_reset(1'b1);
    repeat (3) cycle(1'b1, 1'b0);

    // Randomised traffic with mostly-held request levels and occasional resets.
    rx = 1'b0;
    ry = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 20) rx = ~rx;
      if ($urandom_range(0, 99) < 20) ry = ~ry;
      if ($urandom_range(0, 99) < 15) begin
        rx = 1'b1;
        ry = 1'b1;
      end
      if ((i % 200) == 199) async_reset(1'b0);
      cycle(rx, ry);
    end

    repeat (3) cycle(1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
